systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Upstream stage of the systolic array. Accepts one matrix-vector job as a stream of rows (one input-vector element plus one weight per output lane per beat) over a valid/ready handshake. Drives the array's scalar input port and its per-lane weight ports with the diagonal skew the array requires: lane j delayed by j cycles, with zero padding. Pulses `done` when the last lane has received its final weight.

## Interface
- `SIZE`, 2: number of output lanes. Equals the array's `size`. Must be ≥ 1.
- `WIDTH`, 32: data width of every element. Two's complement, signed.
- `MAX_K`, 16: maximum rows per job. Must be ≥ 1.
- `clk`  in  1: single clock. All logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: upstream beat valid.
- `in_ready`  out  1: feeder can accept a beat.
- `in_x`  in  WIDTH: input-vector element k.
- `in_w`  in  SIZE*WIDTH: weights W[k][j]; lane j at bits `[j*WIDTH +: WIDTH]`.
- `in_last`  in  1: beat is the final row of the job.
- `input_weight`  out  WIDTH: scalar stream to the array.
- `net_weight`  out  SIZE*WIDTH: skewed weight lanes to the array; lane j at `[j*WIDTH +: WIDTH]`.
- `busy`  out  1: a job is in progress.
- `done`  out  1: one-cycle pulse when the job has been fully presented.

## Operation
- A beat is accepted on a rising edge where `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready`=1, `busy`=0. An accepted beat goes to FEED, or to DRAIN if it is the last beat.
  - FEED: `in_ready`=1, `busy`=1. Stays in FEED until the last beat is accepted, then goes to DRAIN.
  - DRAIN: `in_ready`=0, `busy`=1. Counts SIZE-1 cycles, then asserts `done` and returns to IDLE.
- The last beat is the accepted beat with `in_last`=1, or the MAX_K-th accepted beat of the job (implicit last; `in_last` is ignored on it).
- The row counter is $clog2(MAX_K+1) bits and clears on return to IDLE.
- Datapath:
  - `input_weight` and lane 0 are single registers.
  - Lane j (j ≥ 1) is a j-stage delay line behind a register loaded with `in_w` lane j.
  - Every cycle with no accepted beat (bubble in FEED, every DRAIN cycle, IDLE) loads zero into `input_weight` and into the entry of every lane. Delay lines keep shifting. A bubble is therefore a zero row, which the MAC array tolerates. Skew is never broken.
- There is no arithmetic: values pass through bit-exact, sign preserved.
- SIZE=1: DRAIN lasts 0 cycles; `done` is asserted in the cycle right after the last beat.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `input_weight`=0, all `net_weight` lanes and delay stages=0, `busy`=0, `done`=0, `in_ready`=0.
  - State is IDLE, counters are 0.
  - `in_ready` is registered and rises on the first edge after reset release.
- A beat accepted at edge t appears on `input_weight` and lane 0 during cycle t+1, and on lane j during cycle t+1+j.
- Last beat accepted at edge t:
  - `in_ready`=0 during cycles t+1 … t+SIZE.
  - `done`=1 during cycle t+SIZE only.
  - `in_ready`=1 again in cycle t+SIZE+1.
  - `busy` is high from the cycle after the first accepted beat through the `done` cycle inclusive.
- Back-to-back jobs: the first beat of the next job can be accepted at the edge ending cycle t+SIZE+1. This leaves no overlap between jobs in any lane.
- Reset asserted mid-job aborts the job immediately: all outputs go to reset values, no `done` is generated, and partial lane contents are discarded.
- `in_valid` without `in_ready` (DRAIN, or the reset release cycle): the beat is not consumed. Upstream must hold it.

## Test plan
- SIZE=2, beats (x,w0,w1) = (4,1,2), (3,3,4), (4,5,6) with last, accepted at edges 0–2 -> required (`input_weight`, lane0, lane1) per cycle:
  - c1 (4,1,0), c2 (3,3,2), c3 (4,5,4), c4 (0,0,6) with `done`=1.
  - c5 all zero, `in_ready`=1.
- Same job with `in_valid` low for one cycle between beats 1 and 2 -> identical values shifted one cycle from beat 2 onward. One all-zero row appears in every lane at the bubble position. `done` occurs one cycle later.
- MAX_K=4, SIZE=2, five valid beats, none with `in_last` -> the fourth beat ends the job and `in_ready` drops. The fifth beat is held and accepted as row 0 of the next job after `done`.
- Negative data: x=-7 (0xFFFFFFF9), w0=-1, w1=0x80000000, single last beat -> bit-exact values on the outputs with the 1-cycle lane1 skew. `done` occurs in cycle 2.
- `rst_n` pulsed low for a partial cycle during DRAIN -> all outputs 0 asynchronously. No `done` pulse. `in_ready`=1 one cycle after release. A new job then runs correctly.
- SIZE=1, two beats (5,2), (6,3) with last -> lane0 shows 2 then 3. `done`=1 in the cycle showing 3. `in_ready` is never low for more than 1 cycle.

Source files
------------

// File: rtl/systolic_feeder.sv
// Feeds one matrix-vector job into the systolic array with a diagonal lane skew.
// Lane j lags lane 0 by j cycles; idle cycles inject zero rows.
module systolic_feeder #(
    parameter int SIZE  = 2,
    parameter int WIDTH = 32,
    parameter int MAX_K = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_x,
    input  logic [SIZE*WIDTH-1:0]   in_w,
    input  logic                    in_last,
    output logic [WIDTH-1:0]        input_weight,
    output logic [SIZE*WIDTH-1:0]   net_weight,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = $clog2(MAX_K + 1);
    localparam int DW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   rows;
    logic [DW-1:0]   dcnt;
    logic            ready_q;
    logic            accept;
    logic            last_beat;
    logic            drain_end;

    assign in_ready  = ready_q;
    assign accept    = in_valid && ready_q;
    assign last_beat = in_last || (rows == CW'(MAX_K - 1));
    assign drain_end = (state == DRAIN) && (dcnt == DW'(SIZE - 1));

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = last_beat ? DRAIN : FEED;
            end
            FEED: begin
                busy = 1'b1;
                if (accept && last_beat) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_end) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ready is registered from the next state so it drops the cycle after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            rows    <= '0;
            dcnt    <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != DRAIN);
            if (state == DRAIN) rows <= '0;
            else if (accept) rows <= rows + 1'b1;
            if (state != DRAIN || drain_end) dcnt <= '0;
            else dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) input_weight <= '0;
        else input_weight <= accept ? in_x : '0;
    end

    for (genvar j = 0; j < SIZE; j++) begin : g_lane
        logic [WIDTH-1:0] stage [0:j];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= j; i++) stage[i] <= '0;
            end else begin
                stage[0] <= accept ? in_w[j*WIDTH +: WIDTH] : '0;
                for (int i = 1; i <= j; i++) stage[i] <= stage[i-1];
            end
        end

        assign net_weight[j*WIDTH +: WIDTH] = stage[j];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: SIZE=2 and SIZE=1 instances against a
// cycle-indexed model of accepted rows, job boundaries and drain windows.
module tb_systolic_feeder;

    localparam int MK = 4;
    localparam int HN = 4096;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_ready, a_last, a_busy, a_done;
    logic [31:0] a_x, a_iw;
    logic [63:0] a_w, a_nw;

    logic        b_valid, b_ready, b_last, b_busy, b_done;
    logic [31:0] b_x, b_iw, b_w, b_nw;

    systolic_feeder #(.SIZE(2), .WIDTH(32), .MAX_K(MK)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid), .in_ready(a_ready),
        .in_x(a_x), .in_w(a_w), .in_last(a_last),
        .input_weight(a_iw), .net_weight(a_nw),
        .busy(a_busy), .done(a_done)
    );

    systolic_feeder #(.SIZE(1), .WIDTH(32), .MAX_K(MK)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_ready(b_ready),
        .in_x(b_x), .in_w(b_w), .in_last(b_last),
        .input_weight(b_iw), .net_weight(b_nw),
        .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [98:0] obs_a;
    logic [66:0] obs_b;
    assign obs_a = {a_ready, a_busy, a_done, a_iw, a_nw};
    assign obs_b = {b_ready, b_busy, b_done, b_iw, b_nw};

    typedef struct {
        bit          bub;
        logic [31:0] x;
        logic [63:0] w;
        bit          last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

    int tests = 0;
    int fails = 0;

    // model: rows accepted per edge, job bookkeeping, expected outputs
    int          cyc;
    bit          rdy_e  [2];
    int          rows   [2];
    bit          open_j [2];
    int          last_e [2];
    bit          acc_f  [2];
    logic        hv [2][HN];
    logic [31:0] hx [2][HN];
    logic [31:0] hw [2][2][HN];
    logic [98:0] exp_a;
    logic [66:0] exp_b;

    function automatic beat_t mk(logic [31:0] x, logic [31:0] w0,
                                 logic [31:0] w1, bit l);
        beat_t b;
        b.bub  = 1'b0;
        b.x    = x;
        b.w    = {w1, w0};
        b.last = l;
        return b;
    endfunction

    function automatic beat_t bubble();
        beat_t b;
        b.bub  = 1'b1;
        b.x    = '0;
        b.w    = '0;
        b.last = 1'b0;
        return b;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            rdy_e[i]  = 1'b0;
            rows[i]   = 0;
            open_j[i] = 1'b0;
            last_e[i] = -100;
            acc_f[i]  = 1'b0;
            for (int k = 0; k < HN; k++) hv[i][k] = 1'b0;
        end
        exp_a = '0;
        exp_b = '0;
    endtask

    task automatic tick();
        logic        vv, ll;
        logic [31:0] xx, w0, w1, iw;
        logic [31:0] ln [2];
        logic        dn, bz;
        int          sz, c, e;
        @(posedge clk);
        if (cyc >= HN - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HN - 2);
            $fatal(1);
        end
        for (int i = 0; i < 2; i++) begin
            vv = (i == 0) ? a_valid : b_valid;
            ll = (i == 0) ? a_last : b_last;
            xx = (i == 0) ? a_x : b_x;
            w0 = (i == 0) ? a_w[31:0] : b_w;
            w1 = (i == 0) ? a_w[63:32] : 32'h0;
            acc_f[i]      = vv && rdy_e[i];
            hv[i][cyc]    = acc_f[i];
            hx[i][cyc]    = xx;
            hw[i][0][cyc] = w0;
            hw[i][1][cyc] = w1;
            if (acc_f[i]) begin
                rows[i]++;
                if (ll || rows[i] == MK) begin
                    last_e[i] = cyc;
                    rows[i]   = 0;
                    open_j[i] = 1'b0;
                end else begin
                    open_j[i] = 1'b1;
                end
            end
        end
        cyc++;
        c = cyc;
        for (int i = 0; i < 2; i++) begin
            sz       = (i == 0) ? 2 : 1;
            rdy_e[i] = !(last_e[i] >= c - sz && last_e[i] <= c - 1);
            dn       = (last_e[i] == c - sz);
            bz       = open_j[i] || !rdy_e[i];
            iw       = hv[i][c-1] ? hx[i][c-1] : 32'h0;
            ln[0]    = 32'h0;
            ln[1]    = 32'h0;
            for (int j = 0; j < sz; j++) begin
                e = c - 1 - j;
                if (e >= 0 && hv[i][e]) ln[j] = hw[i][j][e];
            end
            if (i == 0) exp_a = {rdy_e[0], bz, dn, iw, ln[1], ln[0]};
            else        exp_b = {rdy_e[1], bz, dn, iw, ln[0]};
        end
        #1;
    endtask

    task automatic cycle();
        if (qa.size() > 0 && !qa[0].bub) begin
            a_valid = 1'b1;
            a_x     = qa[0].x;
            a_w     = qa[0].w;
            a_last  = qa[0].last;
        end else begin
            a_valid = 1'b0;
            a_x     = $urandom;
            a_w     = {$urandom, $urandom};
            a_last  = 1'($urandom_range(0, 1));
        end
        if (qb.size() > 0 && !qb[0].bub) begin
            b_valid = 1'b1;
            b_x     = qb[0].x;
            b_w     = qb[0].w[31:0];
            b_last  = qb[0].last;
        end else begin
            b_valid = 1'b0;
            b_x     = $urandom;
            b_w     = $urandom;
            b_last  = 1'($urandom_range(0, 1));
        end
        tick();
        if (qa.size() > 0 && (qa[0].bub || acc_f[0])) qa.delete(0);
        if (qb.size() > 0 && (qb[0].bub || acc_f[1])) qb.delete(0);
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (obs_a !== '0) begin
            fails++;
            $display("FAIL reset_a got=%h exp=0", obs_a);
        end
        tests++;
        if (obs_b !== '0) begin
            fails++;
            $display("FAIL reset_b got=%h exp=0", obs_b);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        reset_model();
        #1;
        tests++;
        if ({a_ready, b_ready} !== 2'b00) begin
            fails++;
            $display("FAIL release_ready got=%b exp=00", {a_ready, b_ready});
        end
        for (int n = 0; n < 2; n++) begin
            cycle();
            tests++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                fails++;
                $display("FAIL after_release got=%h/%h exp=%h/%h",
                         obs_a, obs_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] piw [5] = '{32'd4, 32'd3, 32'd4, 32'd0, 32'd0};
        logic [31:0] pl0 [5] = '{32'd1, 32'd3, 32'd5, 32'd0, 32'd0};
        logic [31:0] pl1 [5] = '{32'd0, 32'd2, 32'd4, 32'd6, 32'd0};
        logic        pd  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        pr  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        qa.push_back(mk(32'd4, 32'd1, 32'd2, 1'b0));
        qa.push_back(mk(32'd3, 32'd3, 32'd4, 1'b0));
        qa.push_back(mk(32'd4, 32'd5, 32'd6, 1'b1));
        for (int k = 1; k <= 6; k++) begin
            cycle();
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL directed_model k=%0d got=%h exp=%h", k, obs_a, exp_a);
            end
            if (k <= 5) begin
                tests++;
                if ({a_ready, a_done, a_iw, a_nw} !==
                    {pr[k-1], pd[k-1], piw[k-1], pl1[k-1], pl0[k-1]}) begin
                    fails++;
                    $display("FAIL directed_table k=%0d got=%h exp=%h", k,
                             {a_ready, a_done, a_iw, a_nw},
                             {pr[k-1], pd[k-1], piw[k-1], pl1[k-1], pl0[k-1]});
                end
            end
        end
    endtask

    task automatic test_bubble();
        int idle = 0;
        qa.push_back(mk(32'd4, 32'd1, 32'd2, 1'b0));
        qa.push_back(mk(32'd3, 32'd3, 32'd4, 1'b0));
        qa.push_back(bubble());
        qa.push_back(mk(32'd4, 32'd5, 32'd6, 1'b1));
        for (int n = 1; n <= 40 && idle < 4; n++) begin
            if (qa.size() == 0) idle++;
            cycle();
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL bubble n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            if (n == 5) begin
                tests++;
                if ({a_done, a_nw[63:32]} !== {1'b1, 32'd6}) begin
                    fails++;
                    $display("FAIL bubble_done got=%h exp=%h",
                             {a_done, a_nw[63:32]}, {1'b1, 32'd6});
                end
            end
        end
        tests++;
        if (idle < 4) begin
            fails++;
            $display("FAIL bubble_timeout idle=%0d need=4", idle);
        end
    endtask

    task automatic test_max_k();
        int idle = 0;
        int accs = 0;
        for (int i = 0; i < 5; i++)
            qa.push_back(mk($urandom, $urandom, $urandom, 1'b0));
        qa.push_back(mk($urandom, $urandom, $urandom, 1'b1));
        for (int n = 1; n <= 60 && idle < 4; n++) begin
            if (qa.size() == 0) idle++;
            cycle();
            if (acc_f[0]) accs++;
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL max_k n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            if (accs == 4 && acc_f[0]) begin
                tests++;
                if (a_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL max_k_ready got=%b exp=0", a_ready);
                end
            end
        end
        tests++;
        if (idle < 4 || accs != 6) begin
            fails++;
            $display("FAIL max_k_timeout idle=%0d accepts=%0d need=6", idle, accs);
        end
    endtask

    task automatic test_negative();
        int idle = 0;
        qa.push_back(mk(32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 1'b1));
        for (int n = 1; n <= 20 && idle < 4; n++) begin
            if (qa.size() == 0) idle++;
            cycle();
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL negative n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            if (n == 1 || n == 2) begin
                tests++;
                if ((n == 1 && {a_done, a_iw, a_nw} !==
                     {1'b0, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF}) ||
                    (n == 2 && {a_done, a_iw, a_nw} !==
                     {1'b1, 32'h0, 32'h80000000, 32'h0})) begin
                    fails++;
                    $display("FAIL negative_exact n=%0d got=%h", n,
                             {a_done, a_iw, a_nw});
                end
            end
        end
        tests++;
        if (idle < 4) begin
            fails++;
            $display("FAIL negative_timeout idle=%0d need=4", idle);
        end
    endtask

    task automatic test_reset_drain();
        int n;
        int idle = 0;
        qa.push_back(mk($urandom, $urandom, $urandom, 1'b0));
        qa.push_back(mk($urandom, $urandom, $urandom, 1'b1));
        for (n = 0; n < 20 && rdy_e[0]; n++) begin
            cycle();
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL pre_reset n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
        end
        tests++;
        if (rdy_e[0] || a_busy !== 1'b1) begin
            fails++;
            $display("FAIL drain_reached busy=%b exp=1", a_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs_a !== '0) begin
            fails++;
            $display("FAIL async_reset got=%h exp=0", obs_a);
        end
        #1;
        rst_n = 1'b1;
        reset_model();
        qa.delete();
        for (int k = 0; k < 3; k++)
            qa.push_back(mk($urandom, $urandom, $urandom, k == 2));
        for (n = 1; n <= 40 && idle < 4; n++) begin
            if (qa.size() == 0) idle++;
            cycle();
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL post_reset n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
        end
        tests++;
        if (idle < 4) begin
            fails++;
            $display("FAIL post_reset_timeout idle=%0d need=4", idle);
        end
    endtask

    task automatic test_size1();
        int idle = 0;
        qb.push_back(mk(32'd5, 32'd2, 32'd0, 1'b0));
        qb.push_back(mk(32'd6, 32'd3, 32'd0, 1'b1));
        for (int n = 1; n <= 20 && idle < 4; n++) begin
            if (qb.size() == 0) idle++;
            cycle();
            tests++;
            if (obs_b !== exp_b) begin
                fails++;
                $display("FAIL size1 n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
            if (n <= 2) begin
                tests++;
                if ({b_done, b_nw} !== ((n == 1) ? {1'b0, 32'd2} : {1'b1, 32'd3})) begin
                    fails++;
                    $display("FAIL size1_exact n=%0d got=%h", n, {b_done, b_nw});
                end
            end
        end
        tests++;
        if (idle < 4) begin
            fails++;
            $display("FAIL size1_timeout idle=%0d need=4", idle);
        end
    endtask

    task automatic test_random_back_to_back();
        int idle = 0;
        int len;
        for (int j = 0; j < 25; j++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) qa.push_back(bubble());
                qa.push_back(mk($urandom, $urandom, $urandom, k == len - 1));
            end
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) qb.push_back(bubble());
                qb.push_back(mk($urandom, $urandom, 32'd0, k == len - 1));
            end
        end
        for (int n = 1; n <= 1500 && idle < 4; n++) begin
            if (qa.size() == 0 && qb.size() == 0) idle++;
            cycle();
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL random_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            tests++;
            if (obs_b !== exp_b) begin
                fails++;
                $display("FAIL random_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
        end
        tests++;
        if (idle < 4) begin
            fails++;
            $display("FAIL random_timeout idle=%0d need=4", idle);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_x     = '0;
        a_w     = '0;
        a_last  = 1'b0;
        b_valid = 1'b0;
        b_x     = '0;
        b_w     = '0;
        b_last  = 1'b0;
        cyc     = 0;
        reset_model();
        test_reset();
        test_directed();
        test_bubble();
        test_max_k();
        test_negative();
        test_reset_drain();
        test_size1();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
